// File: rtl/axis_spi_slave_fifo.sv
// rtl/axis_spi_slave_fifo.sv - oversampled SPI slave with AXI-Stream TX/RX FIFOs
// Everything runs on clk_i; SPI pins pass through synchronisers and SCLK edges are detected from samples.

module axis_spi_slave_fifo_buf #(
    parameter int W     = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk_i,
    input  logic                     arstn_i,
    input  logic                     push_i,
    input  logic [W-1:0]             wdata_i,
    input  logic                     pop_i,
    output logic [W-1:0]             rdata_o,
    output logic                     empty_o,
    output logic                     full_o,
    output logic [$clog2(DEPTH):0]   level_o
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0]  wr_ptr_q, rd_ptr_q;
    logic         wr_en, rd_en;

    assign level_o = wr_ptr_q - rd_ptr_q;
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign rd_en   = pop_i & ~empty_o;
    // A push into a full FIFO is accepted only when a pop frees the slot in the same cycle.
    assign wr_en   = push_i & (~full_o | rd_en);
    assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end
endmodule

module axis_spi_slave_fifo #(
    parameter int                    DATA_WIDTH    = 8,
    parameter int                    FIFO_DEPTH    = 16,
    parameter int                    SYNC_STAGES   = 2,
    parameter logic [DATA_WIDTH-1:0] UNDERRUN_WORD = '0
) (
    input  logic                          clk_i,
    input  logic                          arstn_i,
    input  logic [1:0]                    mode_i,
    input  logic                          spi_clk_i,
    input  logic                          spi_cs_i,
    input  logic                          spi_mosi_i,
    output logic                          spi_miso_o,
    output logic                          spi_miso_oe_o,
    input  logic [DATA_WIDTH-1:0]         s_axis_tdata,
    input  logic                          s_axis_tvalid,
    output logic                          s_axis_tready,
    output logic [DATA_WIDTH-1:0]         m_axis_tdata,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic [$clog2(FIFO_DEPTH):0]   tx_level_o,
    output logic [$clog2(FIFO_DEPTH):0]   rx_level_o,
    output logic                          tx_underrun_o,
    output logic                          rx_overrun_o,
    output logic                          frame_err_o
);
    localparam int CW = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

    typedef enum logic {IDLE, ACTIVE} state_t;

    logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
    logic                   sclk_prev_q, cs_prev_q;
    logic                   sclk_s, cs_s, mosi_s;
    logic                   sclk_rise, sclk_fall, cs_rise, cs_fall;
    logic                   lead_edge, trail_edge, sample_edge, shift_edge;

    state_t                 state_q;
    logic                   cpol_q, cpha_q, done_q, miso_q;
    logic [CW-1:0]          bit_cnt_q;
    logic [DATA_WIDTH-1:0]  tx_sr_q, rx_sr_q;
    logic                   tx_underrun_q, rx_overrun_q, frame_err_q;

    logic                   load_req, load_cpha;
    logic [DATA_WIDTH-1:0]  load_word, tx_rdata, rx_rdata;
    logic                   tx_empty, tx_full, rx_empty, rx_full;

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            sclk_sync_q <= '0;
            cs_sync_q   <= '1;
            mosi_sync_q <= '0;
            sclk_prev_q <= 1'b0;
            cs_prev_q   <= 1'b1;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_clk_i};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs_i};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi_i};
            sclk_prev_q <= sclk_s;
            cs_prev_q   <= cs_s;
        end
    end

    assign sclk_s      = sclk_sync_q[SYNC_STAGES-1];
    assign cs_s        = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s      = mosi_sync_q[SYNC_STAGES-1];
    assign sclk_rise   = sclk_s & ~sclk_prev_q;
    assign sclk_fall   = ~sclk_s & sclk_prev_q;
    assign cs_rise     = cs_s & ~cs_prev_q;
    assign cs_fall     = ~cs_s & cs_prev_q;
    assign lead_edge   = cpol_q ? sclk_fall : sclk_rise;
    assign trail_edge  = cpol_q ? sclk_rise : sclk_fall;
    assign sample_edge = cpha_q ? trail_edge : lead_edge;
    assign shift_edge  = cpha_q ? lead_edge : trail_edge;

    assign load_req  = ((state_q == IDLE) & cs_fall) | ((state_q == ACTIVE) & done_q & ~cs_rise);
    assign load_cpha = (state_q == IDLE) ? mode_i[0] : cpha_q;
    assign load_word = tx_empty ? UNDERRUN_WORD : tx_rdata;

    // The first shift edge of each word (bit counter 0) never advances the register: in CPHA=0
    // it is the trailing edge after the previous word's last sample, in CPHA=1 it presents the MSB.
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            state_q       <= IDLE;
            cpol_q        <= 1'b0;
            cpha_q        <= 1'b0;
            done_q        <= 1'b0;
            bit_cnt_q     <= '0;
            tx_sr_q       <= UNDERRUN_WORD;
            miso_q        <= UNDERRUN_WORD[DATA_WIDTH-1];
            rx_sr_q       <= '0;
            tx_underrun_q <= 1'b0;
            rx_overrun_q  <= 1'b0;
            frame_err_q   <= 1'b0;
        end else begin
            done_q        <= 1'b0;
            tx_underrun_q <= 1'b0;
            frame_err_q   <= 1'b0;
            rx_overrun_q  <= done_q & rx_full & ~m_axis_tready;
            if (load_req) begin
                tx_sr_q       <= load_word;
                tx_underrun_q <= tx_empty;
                if (!load_cpha) miso_q <= load_word[DATA_WIDTH-1];
            end
            case (state_q)
                IDLE: begin
                    if (cs_fall) begin
                        cpol_q    <= mode_i[1];
                        cpha_q    <= mode_i[0];
                        bit_cnt_q <= '0;
                        state_q   <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (cs_rise) begin
                        state_q     <= IDLE;
                        frame_err_q <= (bit_cnt_q != '0);
                        bit_cnt_q   <= '0;
                    end else begin
                        if (sample_edge) begin
                            rx_sr_q <= {rx_sr_q[DATA_WIDTH-2:0], mosi_s};
                            if (bit_cnt_q == LAST_BIT) begin
                                bit_cnt_q <= '0;
                                done_q    <= 1'b1;
                            end else begin
                                bit_cnt_q <= bit_cnt_q + 1'b1;
                            end
                        end
                        if (shift_edge && bit_cnt_q != '0) begin
                            tx_sr_q <= tx_sr_q << 1;
                            miso_q  <= tx_sr_q[DATA_WIDTH-2];
                        end else if (shift_edge && cpha_q) begin
                            miso_q  <= tx_sr_q[DATA_WIDTH-1];
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    axis_spi_slave_fifo_buf #(.W(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk_i   (clk_i),
        .arstn_i (arstn_i),
        .push_i  (s_axis_tvalid),
        .wdata_i (s_axis_tdata),
        .pop_i   (load_req),
        .rdata_o (tx_rdata),
        .empty_o (tx_empty),
        .full_o  (tx_full),
        .level_o (tx_level_o)
    );

    axis_spi_slave_fifo_buf #(.W(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk_i   (clk_i),
        .arstn_i (arstn_i),
        .push_i  (done_q),
        .wdata_i (rx_sr_q),
        .pop_i   (m_axis_tready),
        .rdata_o (rx_rdata),
        .empty_o (rx_empty),
        .full_o  (rx_full),
        .level_o (rx_level_o)
    );

    assign s_axis_tready = ~tx_full;
    assign m_axis_tvalid = ~rx_empty;
    assign m_axis_tdata  = rx_empty ? '0 : rx_rdata;
    assign spi_miso_o    = miso_q;
    assign spi_miso_oe_o = ~cs_s;
    assign tx_underrun_o = tx_underrun_q;
    assign rx_overrun_o  = rx_overrun_q;
    assign frame_err_o   = frame_err_q;
endmodule

// File: tb/tb_axis_spi_slave_fifo.sv
// tb/tb_axis_spi_slave_fifo.sv - directed bench for axis_spi_slave_fifo with a behavioural SPI master
module tb_axis_spi_slave_fifo;
    logic       clk_i = 1'b0;
    logic       arstn_i = 1'b0;
    logic [1:0] mode_i = 2'd0;
    logic       spi_clk_i = 1'b0;
    logic       spi_cs_i = 1'b1;
    logic       spi_mosi_i = 1'b0;
    logic       spi_miso_o, spi_miso_oe_o;
    logic [7:0] s_axis_tdata = '0;
    logic       s_axis_tvalid = 1'b0;
    logic       s_axis_tready;
    logic [7:0] m_axis_tdata;
    logic       m_axis_tvalid;
    logic       m_axis_tready = 1'b1;
    logic [4:0] tx_level_o, rx_level_o;
    logic       tx_underrun_o, rx_overrun_o, frame_err_o;

    axis_spi_slave_fifo #(
        .DATA_WIDTH(8), .FIFO_DEPTH(16), .SYNC_STAGES(2), .UNDERRUN_WORD(8'hFF)
    ) dut (
        .clk_i(clk_i), .arstn_i(arstn_i), .mode_i(mode_i),
        .spi_clk_i(spi_clk_i), .spi_cs_i(spi_cs_i), .spi_mosi_i(spi_mosi_i),
        .spi_miso_o(spi_miso_o), .spi_miso_oe_o(spi_miso_oe_o),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .tx_level_o(tx_level_o), .rx_level_o(rx_level_o),
        .tx_underrun_o(tx_underrun_o), .rx_overrun_o(rx_overrun_o), .frame_err_o(frame_err_o)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    int n_checks = 0, n_pass = 0;
    int n_und = 0, n_ovr = 0, n_ferr = 0;
    int rise_cyc = 0, last_samp_cyc = 0, und_snap = 0;
    logic tvalid_prev = 1'b0;
    logic [7:0] rxq[$];
    logic [7:0] mosi_words[20];
    logic [7:0] miso_words[20];

    always @(posedge clk_i) cyc++;

    always @(negedge clk_i) begin
        if (tx_underrun_o) n_und++;
        if (rx_overrun_o) n_ovr++;
        if (frame_err_o) n_ferr++;
        if (m_axis_tvalid && m_axis_tready) rxq.push_back(m_axis_tdata);
        if (m_axis_tvalid && !tvalid_prev) rise_cyc = cyc;
        tvalid_prev = m_axis_tvalid;
    end

    initial begin
        #10_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic tx_push(input logic [7:0] w);
        s_axis_tdata  = w;
        s_axis_tvalid = 1'b1;
        idle(1);
        s_axis_tvalid = 1'b0;
    endtask

    task automatic rx_expect(input string tag, input logic [7:0] exp);
        logic [31:0] got;
        got = (rxq.size() > 0) ? {24'd0, rxq.pop_front()} : 32'hFFFF_FFFF;
        check(tag, got, {24'd0, exp});
    endtask

    // SCLK half period is 5 clk cycles (SCLK = clk/10); master samples MISO just before its sample edge.
    task automatic spi_burst(input int nwords, input int nbits, input bit raise_cs);
        logic       cpha;
        logic [7:0] mo, mi;
        cpha      = mode_i[0];
        spi_clk_i = mode_i[1];
        idle(10);
        spi_cs_i = 1'b0;
        idle(10);
        for (int w = 0; w < nwords; w++) begin
            mo = mosi_words[w];
            mi = '0;
            for (int b = 0; b < nbits; b++) begin
                if (!cpha) begin
                    spi_mosi_i = mo[7-b];
                    idle(5);
                    mi[7-b] = spi_miso_o;
                    spi_clk_i = ~spi_clk_i;
                    last_samp_cyc = cyc;
                    und_snap = n_und;
                    idle(5);
                    spi_clk_i = ~spi_clk_i;
                end else begin
                    idle(5);
                    spi_clk_i = ~spi_clk_i;
                    spi_mosi_i = mo[7-b];
                    idle(5);
                    mi[7-b] = spi_miso_o;
                    spi_clk_i = ~spi_clk_i;
                    last_samp_cyc = cyc;
                    und_snap = n_und;
                end
            end
            miso_words[w] = mi;
        end
        idle(5);
        if (raise_cs) begin
            spi_cs_i = 1'b1;
            idle(10);
        end
    endtask

    int base_und, base_ovr, base_ferr;

    initial begin
        idle(3);
        check("rst_miso", {31'd0, spi_miso_o}, 32'd1);
        check("rst_oe", {31'd0, spi_miso_oe_o}, 32'd0);
        check("rst_tready", {31'd0, s_axis_tready}, 32'd1);
        check("rst_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
        check("rst_tdata", {24'd0, m_axis_tdata}, 32'd0);
        check("rst_levels", {22'd0, tx_level_o, rx_level_o}, 32'd0);
        check("rst_pulses", {29'd0, tx_underrun_o, rx_overrun_o, frame_err_o}, 32'd0);
        arstn_i = 1'b1;
        idle(5);

        // Mode 0 single word, also measures RX latency
        mode_i = 2'd0;
        m_axis_tready = 1'b0;
        tx_push(8'hA5);
        check("m0_tx_level_pre", {27'd0, tx_level_o}, 32'd1);
        mosi_words[0] = 8'h3C;
        base_und = n_und;
        spi_burst(1, 8, 1'b1);
        check("m0_miso", {24'd0, miso_words[0]}, 32'hA5);
        check("m0_rx_latency", rise_cyc - last_samp_cyc, 32'd4);
        check("m0_rx_level", {27'd0, rx_level_o}, 32'd1);
        m_axis_tready = 1'b1;
        idle(2);
        rx_expect("m0_rx", 8'h3C);
        check("m0_tx_level", {27'd0, tx_level_o}, 32'd0);
        check("m0_no_underrun", und_snap - base_und, 32'd0);
        check("m0_no_ovr_ferr", n_ovr + n_ferr, 32'd0);

        for (int m = 1; m < 4; m++) begin
            mode_i = m[1:0];
            tx_push(8'h81);
            mosi_words[0] = 8'h7E;
            base_und = n_und;
            spi_burst(1, 8, 1'b1);
            check($sformatf("mode%0d_miso", m), {24'd0, miso_words[0]}, 32'h81);
            rx_expect($sformatf("mode%0d_rx", m), 8'h7E);
            check($sformatf("mode%0d_no_underrun", m), und_snap - base_und, 32'd0);
        end

        mode_i = 2'd0;
        for (int i = 0; i < 4; i++) begin
            tx_push(8'h11 + 8'(i));
            mosi_words[i] = 8'h01 + 8'(i);
        end
        spi_burst(4, 8, 1'b1);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("burst_miso%0d", i), {24'd0, miso_words[i]}, 32'h11 + i);
            rx_expect($sformatf("burst_rx%0d", i), 8'h01 + 8'(i));
        end

        mosi_words[0] = 8'h5A;
        base_und = n_und;
        spi_burst(1, 8, 1'b1);
        check("underrun_miso", {24'd0, miso_words[0]}, 32'hFF);
        check("underrun_pulses", und_snap - base_und, 32'd1);
        rx_expect("underrun_rx", 8'h5A);

        m_axis_tready = 1'b0;
        for (int i = 0; i < 17; i++) mosi_words[i] = 8'h20 + 8'(i);
        base_ovr = n_ovr;
        spi_burst(17, 8, 1'b1);
        check("ovr_rx_level", {27'd0, rx_level_o}, 32'd16);
        check("ovr_pulses", n_ovr - base_ovr, 32'd1);
        check("ovr_tready_full_tvalid", {31'd0, m_axis_tvalid}, 32'd1);
        m_axis_tready = 1'b1;
        idle(20);
        check("ovr_drained", rxq.size(), 32'd16);
        for (int i = 0; i < 16; i++) rx_expect($sformatf("ovr_rx%0d", i), 8'h20 + 8'(i));

        base_ferr = n_ferr;
        mosi_words[0] = 8'hC0;
        spi_burst(1, 5, 1'b1);
        check("ferr_pulse", n_ferr - base_ferr, 32'd1);
        check("ferr_no_push", rxq.size(), 32'd0);
        mosi_words[0] = 8'h55;
        spi_burst(1, 8, 1'b1);
        rx_expect("ferr_next_rx", 8'h55);
        check("ferr_no_second", n_ferr - base_ferr, 32'd1);

        tx_push(8'h99);
        mosi_words[0] = 8'hF0;
        base_ferr = n_ferr;
        spi_burst(1, 3, 1'b0);
        arstn_i = 1'b0;
        idle(2);
        check("arst_levels", {22'd0, tx_level_o, rx_level_o}, 32'd0);
        check("arst_tready", {31'd0, s_axis_tready}, 32'd1);
        check("arst_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
        check("arst_miso_oe", {30'd0, spi_miso_o, spi_miso_oe_o}, 32'd2);
        check("arst_pulses", {29'd0, tx_underrun_o, rx_overrun_o, frame_err_o}, 32'd0);
        spi_cs_i = 1'b1;
        spi_clk_i = 1'b0;
        spi_mosi_i = 1'b0;
        idle(2);
        arstn_i = 1'b1;
        idle(5);
        tx_push(8'hC3);
        mosi_words[0] = 8'h3A;
        spi_burst(1, 8, 1'b1);
        check("post_rst_miso", {24'd0, miso_words[0]}, 32'hC3);
        rx_expect("post_rst_rx", 8'h3A);
        check("post_rst_no_ferr", n_ferr - base_ferr, 32'd0);
        check("final_rxq_empty", rxq.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
